in_fm_ld_padder: RTL and testbench
==================================

# in_fm_ld_padder

Load-side counterpart of the output-feature-map store filter. It sits between the input-feature-map load FIFO and the on-chip input tile buffer writer. For one input tile it emits exactly Tn*Tr*Tc elements in tile order (tc fastest, then tr, then tn). In-bounds elements are popped from the FIFO. Out-of-bounds (padding) elements are synthesised as zero without touching the FIFO.

## Interface
Parameters:
- CW, 16, counter/coordinate width
- DW, 32, data width
- N, 32, total input channels
- R, 64, total input rows
- C, 32, total input columns
- Tn, 16, tile channels
- Tr, 64, tile rows
- Tc, 16, tile columns

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  single-cycle pulse; latches tile bases and begins a tile
- tile_base_n  in  CW  channel base of tile
- tile_base_row  in  CW  row base of tile
- tile_base_col  in  CW  column base of tile
- fifo_empty  in  1  load FIFO empty
- data_from_fifo  in  DW  FIFO head word (first-word-fall-through, valid when !fifo_empty)
- fifo_pop  out  1  consume FIFO head this cycle
- out_valid  out  1  out_data holds an element
- out_data  out  DW  element value (FIFO word or zero)
- out_ready  in  1  downstream accepts the element
- busy  out  1  tile in progress
- done  out  1  one-cycle pulse after the last element is accepted

## Operation
- States:
  - IDLE --start--> RUN
  - RUN --last element issued--> DRAIN
  - DRAIN --output register empty--> DONE
  - DONE --> IDLE (unconditional)
- start is ignored outside IDLE.
- Tile bases are latched on start and held until IDLE.
- Counters tc, tr, tn wrap at Tc, Tr, Tn; all three clear on start.
- legal = (base_n+tn < N) && (base_row+tr < R) && (base_col+tc < C).
  - Sums are evaluated at CW+1 bits so they never wrap.
- Output stage is one register; it is free when !out_valid || out_ready.
- Issue condition in RUN: stage free && (!legal || !fifo_empty).
  - legal element: fifo_pop=1; out_data <= data_from_fifo.
  - illegal element: fifo_pop=0; out_data <= 0.
  - Either way: out_valid <= 1 and the counters advance.
- Issue is strictly in order. A legal element blocked by an empty FIFO stalls all later elements, including padding.
- fifo_pop is combinational and is never asserted when fifo_empty=1, outside RUN, or when the stage is not free.
- When no element issues and out_ready=1, out_valid <= 0.
- While out_valid && !out_ready, out_data and out_valid are held unchanged.
- busy=1 in RUN, DRAIN and DONE.

## Timing
- Reset values: fifo_pop=0, out_valid=0, out_data=0, busy=0, done=0. State returns to IDLE and counters clear.
- Reset mid-tile aborts it:
  - no done pulse;
  - any unconsumed FIFO words stay in the FIFO.
- Latency: start at cycle 0 → first issue at cycle 1 → out_valid at cycle 2.
- Throughput: one element per cycle with out_ready=1 and the FIFO non-empty.
- done asserts the cycle after the final element is accepted (out_valid && out_ready) and lasts exactly 1 cycle. busy drops in the same cycle as the IDLE transition.
- A start in the cycle done is high is ignored. A start one cycle later is accepted.
- Total pops per tile equal the legal-element count exactly.

## Test plan
- N=5, R=6, C=6, Tn=2, Tr=4, Tc=4, base (0,0,0), FIFO preloaded 1..32, out_ready=1 → 32 pops; out_data 1..32 in order on consecutive cycles; done 1 cycle after the 32nd accept.
- Same params, base (4,4,4), FIFO holds 11..14 → 4 pops. Nonzero outputs only at tn=0, tr<2, tc<2 (output indices 0,1,4,5 = 11,12,13,14). The other 28 outputs are 0. FIFO is empty at done.
- Base (0,0,0) with out_ready toggling 1,0,0,1 repeatedly → no loss or duplication; out_data stable while stalled; exactly 32 accepts, then done.
- Base (0,0,4), FIFO empty for 10 cycles after start, then fed → no output or pop until data arrives; at tr=0 the padding at tc=2,3 is not emitted before the legal elements at tc=0,1.
- Assert rst after 10 accepts, then start a new tile with base (0,0,0) → outputs cleared in the rst cycle, no done pulse; new tile runs from tc=tr=tn=0 with 32 elements.
- Pulse start during RUN with different bases → ignored; the original tile's legal pattern and element count are unchanged.

Source files
------------

// File: rtl/in_fm_ld_padder.sv
// Input-feature-map load padder: walks one tile in (tn, tr, tc) order, pops in-bounds
// elements from a first-word-fall-through FIFO and emits zero for out-of-bounds padding.
module in_fm_ld_padder #(
    parameter int CW = 16,
    parameter int DW = 32,
    parameter int N  = 32,
    parameter int R  = 64,
    parameter int C  = 32,
    parameter int Tn = 16,
    parameter int Tr = 64,
    parameter int Tc = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [CW-1:0] tile_base_n,
    input  logic [CW-1:0] tile_base_row,
    input  logic [CW-1:0] tile_base_col,
    input  logic          fifo_empty,
    input  logic [DW-1:0] data_from_fifo,
    output logic          fifo_pop,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic          busy,
    output logic          done,
    output logic [1:0]    state_dbg
);

    // Handshake: an element moves downstream in any cycle where out_valid && out_ready;
    // while out_valid && !out_ready the output register holds value and valid unchanged.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [CW:0]   N_W     = (CW+1)'(N);
    localparam logic [CW:0]   R_W     = (CW+1)'(R);
    localparam logic [CW:0]   C_W     = (CW+1)'(C);
    localparam logic [CW-1:0] TN_LAST = CW'(Tn - 1);
    localparam logic [CW-1:0] TR_LAST = CW'(Tr - 1);
    localparam logic [CW-1:0] TC_LAST = CW'(Tc - 1);

    state_t        state_q;
    logic [CW-1:0] base_n_q, base_row_q, base_col_q;
    logic [CW-1:0] tn_q, tr_q, tc_q;
    logic          out_valid_q;
    logic [DW-1:0] out_data_q;
    logic          busy_q;
    logic          done_q;

    logic [CW:0]   sum_n, sum_row, sum_col;
    logic          legal;
    logic          stage_free;
    logic          issue;
    logic          last_elem;

    // Bounds sums carry one extra bit so base + offset can never wrap into range.
    always_comb begin
        sum_n      = {1'b0, base_n_q}   + {1'b0, tn_q};
        sum_row    = {1'b0, base_row_q} + {1'b0, tr_q};
        sum_col    = {1'b0, base_col_q} + {1'b0, tc_q};
        legal      = (sum_n < N_W) && (sum_row < R_W) && (sum_col < C_W);
        stage_free = !out_valid_q || out_ready;
        issue      = !rst && (state_q == S_RUN) && stage_free && (!legal || !fifo_empty);
        last_elem  = (tc_q == TC_LAST) && (tr_q == TR_LAST) && (tn_q == TN_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            base_n_q    <= '0;
            base_row_q  <= '0;
            base_col_q  <= '0;
            tn_q        <= '0;
            tr_q        <= '0;
            tc_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;

            if (issue) begin
                out_valid_q <= 1'b1;
                out_data_q  <= legal ? data_from_fifo : '0;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        base_n_q   <= tile_base_n;
                        base_row_q <= tile_base_row;
                        base_col_q <= tile_base_col;
                        tn_q       <= '0;
                        tr_q       <= '0;
                        tc_q       <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (issue) begin
                        if (tc_q == TC_LAST) begin
                            tc_q <= '0;
                            if (tr_q == TR_LAST) begin
                                tr_q <= '0;
                                tn_q <= (tn_q == TN_LAST) ? '0 : tn_q + 1'b1;
                            end else begin
                                tr_q <= tr_q + 1'b1;
                            end
                        end else begin
                            tc_q <= tc_q + 1'b1;
                        end
                        if (last_elem) begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    // Final element leaves this cycle (or already left): done follows next cycle.
                    if (stage_free) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign fifo_pop  = issue && legal;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_in_fm_ld_padder.sv
// Self-checking bench for in_fm_ld_padder: table of tile scenarios, randomized tiles,
// and hand-written reset sequences, scored against a tile-walk reference model.
module tb_in_fm_ld_padder;

    localparam int CW   = 16;
    localparam int DW   = 32;
    localparam int N    = 5;
    localparam int R    = 6;
    localparam int C    = 6;
    localparam int TN   = 2;
    localparam int TR   = 4;
    localparam int TC   = 4;
    localparam int TILE = TN * TR * TC;
    localparam int BUDGET = 3000;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          start;
    logic [CW-1:0] tile_base_n, tile_base_row, tile_base_col;
    logic          fifo_empty;
    logic [DW-1:0] data_from_fifo;
    logic          fifo_pop;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic          busy;
    logic          done;
    logic [1:0]    state_dbg;

    in_fm_ld_padder #(
        .CW(CW), .DW(DW), .N(N), .R(R), .C(C), .Tn(TN), .Tr(TR), .Tc(TC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .tile_base_n(tile_base_n),
        .tile_base_row(tile_base_row),
        .tile_base_col(tile_base_col),
        .fifo_empty(fifo_empty),
        .data_from_fifo(data_from_fifo),
        .fifo_pop(fifo_pop),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_ready(out_ready),
        .busy(busy),
        .done(done),
        .state_dbg(state_dbg)
    );

    typedef struct {
        int bn, br, bc;
        int word0;
        int rmode;       // 0: always ready, 1: 1,0,0,1 pattern, 2: random
        int delay;       // cycles the FIFO looks empty after start
        int exp_pops;    // -1: take the model's count
        int mid_start;
        int done_start;
    } vec_t;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    int   hold;
    int   accepts, pops, dones, cyc;
    int   first_valid, first_acc, last_acc, done_cyc;
    logic prev_stall;
    logic [DW-1:0] prev_data;
    logic first_legal;
    int   rmode_cur;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void fifo_drive();
        fifo_empty     = (fifo_q.size() == 0) || (hold > 0);
        data_from_fifo = (fifo_q.size() == 0) ? '0 : fifo_q[0];
    endfunction

    // Reference model: walk the tile in tc-fastest order, legal positions consume the
    // next FIFO word, the rest are zero. Returns the legal-element count.
    function automatic int build_expected(input int bn, input int br, input int bc, input int word0);
        int nlegal = 0;
        exp_q.delete();
        fifo_q.delete();
        for (int n = 0; n < TN; n++)
            for (int r = 0; r < TR; r++)
                for (int c = 0; c < TC; c++)
                    if (bn + n < N && br + r < R && bc + c < C) begin
                        exp_q.push_back(DW'(word0 + nlegal));
                        fifo_q.push_back(DW'(word0 + nlegal));
                        nlegal++;
                    end else begin
                        exp_q.push_back('0);
                    end
        return nlegal;
    endfunction

    function automatic void clear_stats();
        accepts = 0; pops = 0; dones = 0; cyc = 0;
        first_valid = -1; first_acc = -1; last_acc = -1; done_cyc = -1;
        prev_stall = 1'b0; prev_data = '0;
    endfunction

    function automatic logic ready_for(input int mode, input int k);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (k % 4 == 0) || (k % 4 == 3);
        return $urandom_range(0, 3) != 0;
    endfunction

    // One clock: sample at the falling edge, update the FIFO model just after the rising edge.
    task automatic cycle();
        logic [DW-1:0] exp_w;
        logic pop_now;
        @(negedge clk);
        if (fifo_pop) begin
            check("pop_when_empty", fifo_empty, 1'b0);
            pops++;
        end
        if (hold > 0 && first_legal) check("hold_no_valid", out_valid, 1'b0);
        if (prev_stall) begin
            check("stall_valid", out_valid, 1'b1);
            check("stall_data", out_data, prev_data);
        end
        if (out_valid && first_valid < 0) first_valid = cyc;
        if (out_valid && out_ready) begin
            accepts++;
            if (first_acc < 0) first_acc = cyc;
            last_acc = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_accept: got data %0d expected no element", out_data);
            end else begin
                exp_w = exp_q.pop_front();
                check("out_data", out_data, exp_w);
            end
        end
        if (done) begin
            dones++;
            done_cyc = cyc;
            check("busy_at_done", busy, 1'b1);
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        pop_now    = fifo_pop;
        @(posedge clk);
        #1;
        if (pop_now && fifo_q.size() > 0) void'(fifo_q.pop_front());
        if (hold > 0) hold--;
        cyc++;
        fifo_drive();
    endtask

    task automatic run_tile(input vec_t v);
        int nlegal;
        nlegal      = build_expected(v.bn, v.br, v.bc, v.word0);
        first_legal = (v.bn < N) && (v.br < R) && (v.bc < C);
        clear_stats();
        rmode_cur     = v.rmode;
        hold          = v.delay;
        fifo_drive();
        tile_base_n   = CW'(v.bn);
        tile_base_row = CW'(v.br);
        tile_base_col = CW'(v.bc);
        start         = 1'b1;
        out_ready     = ready_for(rmode_cur, cyc);
        cycle();
        while (dones == 0 && cyc < BUDGET) begin
            out_ready = ready_for(rmode_cur, cyc);
            start = 1'b0;
            if (v.mid_start != 0 && cyc == 5) begin
                start         = 1'b1;
                tile_base_n   = CW'(1);
                tile_base_row = CW'(1);
                tile_base_col = CW'(1);
            end
            if (v.done_start != 0 && accepts == TILE) start = 1'b1;
            cycle();
        end
        start = 1'b0;
        check("done_seen", dones, 1);
        check("accepts", accepts, TILE);
        check("pops", pops, (v.exp_pops >= 0) ? v.exp_pops : nlegal);
        check("exp_left", exp_q.size(), 0);
        check("fifo_left", fifo_q.size(), 0);
        check("done_after_last_accept", done_cyc, last_acc + 1);
        check("busy_after_done", busy, 1'b0);
        check("idle_after_done", state_dbg, 2'd0);
        if (v.delay == 0) check("first_valid_latency", first_valid, 2);
        else if (first_legal) check("valid_after_feed", first_valid > v.delay, 1'b1);
        if (v.rmode == 0 && v.delay == 0) check("throughput", last_acc - first_acc, TILE - 1);
    endtask

    vec_t tbl[8];
    vec_t rv;

    initial begin
        tbl[0] = '{bn:0, br:0, bc:0, word0:1,   rmode:0, delay:0,  exp_pops:32, mid_start:0, done_start:0};
        tbl[1] = '{bn:4, br:4, bc:4, word0:11,  rmode:0, delay:0,  exp_pops:4,  mid_start:0, done_start:0};
        tbl[2] = '{bn:0, br:0, bc:0, word0:200, rmode:1, delay:0,  exp_pops:32, mid_start:0, done_start:0};
        tbl[3] = '{bn:0, br:0, bc:4, word0:300, rmode:0, delay:10, exp_pops:16, mid_start:0, done_start:0};
        tbl[4] = '{bn:0, br:0, bc:0, word0:400, rmode:0, delay:0,  exp_pops:32, mid_start:1, done_start:0};
        tbl[5] = '{bn:3, br:5, bc:0, word0:500, rmode:2, delay:2,  exp_pops:8,  mid_start:0, done_start:1};
        tbl[6] = '{bn:5, br:0, bc:0, word0:600, rmode:0, delay:0,  exp_pops:0,  mid_start:0, done_start:0};
        tbl[7] = '{bn:0, br:2, bc:5, word0:700, rmode:2, delay:0,  exp_pops:8,  mid_start:0, done_start:0};

        rst = 1'b1; start = 1'b0; out_ready = 1'b0; hold = 0;
        tile_base_n = '0; tile_base_row = '0; tile_base_col = '0;
        fifo_q.delete();
        fifo_drive();
        clear_stats();
        repeat (3) @(posedge clk);
        #1;
        check("rst_fifo_pop", fifo_pop, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_state", state_dbg, 2'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) run_tile(tbl[i]);

        for (int k = 0; k < 8; k++) begin
            rv = '{bn:$urandom_range(0, 6), br:$urandom_range(0, 7), bc:$urandom_range(0, 7),
                   word0:1000 * (k + 1), rmode:2, delay:$urandom_range(0, 3),
                   exp_pops:-1, mid_start:0, done_start:0};
            run_tile(rv);
        end

        // Reset after ten accepts: tile aborts, no done, unconsumed words stay queued.
        void'(build_expected(0, 0, 0, 2000));
        first_legal = 1'b1;
        clear_stats();
        hold = 0;
        fifo_drive();
        tile_base_n = '0; tile_base_row = '0; tile_base_col = '0;
        start = 1'b1;
        out_ready = 1'b1;
        cycle();
        start = 1'b0;
        while (accepts < 10 && cyc < 200) cycle();
        check("pre_rst_accepts", accepts, 10);
        rst = 1'b1;
        @(negedge clk);
        check("rst_cycle_pop", fifo_pop, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_out_data", out_data, 0);
        check("abort_busy", busy, 1'b0);
        check("abort_state", state_dbg, 2'd0);
        check("abort_fifo_words", fifo_q.size(), 21);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_no_done", done, 1'b0);
        end
        @(posedge clk);
        #1;
        run_tile('{bn:0, br:0, bc:0, word0:3000, rmode:0, delay:0, exp_pops:32, mid_start:0, done_start:0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
